// File: rtl/mod12_run_ctrl_if.sv
// Command, shared-counter and completion signals of the mod-12 run controller.
// The controller connects through the slave modport; requesters and the counter use master.
interface mod12_run_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_start;
  logic             req0_dir;
  logic [LEN_W-1:0] req0_len;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_start;
  logic             req1_dir;
  logic [LEN_W-1:0] req1_len;
  logic [3:0]       ctr_count;
  logic             ctr_load;
  logic             ctr_mode;
  logic [3:0]       ctr_data;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [3:0]       done_value;
  logic             done_err;

  modport slave (
    input  req0_valid, req0_start, req0_dir, req0_len,
    input  req1_valid, req1_start, req1_dir, req1_len,
    input  ctr_count,
    output req0_ready, req1_ready,
    output ctr_load, ctr_mode, ctr_data,
    output busy, done, done_id, done_value, done_err
  );

  modport master (
    output req0_valid, req0_start, req0_dir, req0_len,
    output req1_valid, req1_start, req1_dir, req1_len,
    output ctr_count,
    input  req0_ready, req1_ready,
    input  ctr_load, ctr_mode, ctr_data,
    input  busy, done, done_id, done_value, done_err
  );
endinterface

// File: rtl/mod12_run_ctrl.sv
// Round-robin sequencer for a shared mod-12 up/down counter: load, step for len cycles,
// freeze, then report the final value cross-checked against an internal mirror counter.
module mod12_run_ctrl #(
  parameter int LEN_W = 8,
  parameter int MOD   = 12
) (
  input logic             clock,
  input logic             reset,
  mod12_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] MOD_TOP = 4'(MOD - 1);
  localparam logic [3:0] MOD_LIM = 4'(MOD);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [3:0]       start_q, start_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] step_q, step_d;
  logic [3:0]       mirror_q, mirror_d;
  logic             err_q, err_d;
  logic             done_id_q, done_id_d;
  logic [3:0]       done_value_q, done_value_d;

  logic             ready0_s, ready1_s;
  logic             ctr_load_s, ctr_mode_s;
  logic [3:0]       ctr_data_s;
  logic             busy_s, done_s, done_err_s, done_id_s;
  logic [3:0]       done_value_s;

  function automatic logic [3:0] mod_step(input logic [3:0] v, input logic up);
    if (up) begin
      return (v == MOD_TOP) ? 4'd0 : v + 4'd1;
    end else begin
      return (v == 4'd0) ? MOD_TOP : v - 4'd1;
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    start_d      = start_q;
    dir_d        = dir_q;
    step_d       = step_q;
    mirror_d     = mirror_q;
    err_d        = err_q;
    done_id_d    = done_id_q;
    done_value_d = done_value_q;
    ready0_s     = 1'b0;
    ready1_s     = 1'b0;
    ctr_load_s   = 1'b1;
    ctr_mode_s   = 1'b0;
    ctr_data_s   = bus.ctr_count;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    done_err_s   = 1'b0;
    done_id_s    = done_id_q;
    done_value_s = done_value_q;

    case (state_q)
      ST_IDLE: begin
        // prio_q names the requester that wins a tie; it flips to the other side on every grant
        if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
          ready0_s = 1'b1;
          id_d     = 1'b0;
          start_d  = bus.req0_start;
          dir_d    = bus.req0_dir;
          step_d   = bus.req0_len;
          prio_d   = 1'b1;
          state_d  = ST_LOAD;
        end else if (bus.req1_valid) begin
          ready1_s = 1'b1;
          id_d     = 1'b1;
          start_d  = bus.req1_start;
          dir_d    = bus.req1_dir;
          step_d   = bus.req1_len;
          prio_d   = 1'b0;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        busy_s = 1'b1;
        if (start_q >= MOD_LIM) begin
          ctr_data_s = 4'd0;
          mirror_d   = 4'd0;
          err_d      = 1'b1;
        end else begin
          ctr_data_s = start_q;
          mirror_d   = start_q;
          err_d      = 1'b0;
        end
        state_d = (step_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        ctr_load_s = 1'b0;
        ctr_mode_s = dir_q;
        busy_s     = 1'b1;
        mirror_d   = mod_step(mirror_q, dir_q);
        step_d     = step_q - LEN_W'(1);
        state_d    = (step_q == LEN_W'(1)) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        busy_s       = 1'b1;
        done_s       = 1'b1;
        done_id_s    = id_q;
        done_value_s = bus.ctr_count;
        done_err_s   = err_q || (bus.ctr_count != mirror_q);
        done_id_d    = id_q;
        done_value_d = bus.ctr_count;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, arbitration pointer, captured command, mirror and held completion report
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      start_q      <= 4'd0;
      dir_q        <= 1'b0;
      step_q       <= '0;
      mirror_q     <= 4'd0;
      err_q        <= 1'b0;
      done_id_q    <= 1'b0;
      done_value_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      start_q      <= start_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      mirror_q     <= mirror_d;
      err_q        <= err_d;
      done_id_q    <= done_id_d;
      done_value_q <= done_value_d;
    end
  end

  // Reset silences the handshake and report immediately, even mid-run, and freezes the counter
  assign bus.req0_ready = reset ? 1'b0 : ready0_s;
  assign bus.req1_ready = reset ? 1'b0 : ready1_s;
  assign bus.ctr_load   = reset ? 1'b1 : ctr_load_s;
  assign bus.ctr_mode   = reset ? 1'b0 : ctr_mode_s;
  assign bus.ctr_data   = reset ? bus.ctr_count : ctr_data_s;
  assign bus.busy       = reset ? 1'b0 : busy_s;
  assign bus.done       = reset ? 1'b0 : done_s;
  assign bus.done_id    = reset ? 1'b0 : done_id_s;
  assign bus.done_value = reset ? 4'd0 : done_value_s;
  assign bus.done_err   = reset ? 1'b0 : done_err_s;

endmodule

// File: tb/tb_mod12_run_ctrl.sv
// Bench for mod12_run_ctrl: directed scenarios plus random traffic from both requesters,
// checked every cycle against a timeline model of grants, latency and final values.
`timescale 1ns/1ps
module tb_mod12_run_ctrl;
  localparam int LEN_W = 8;

  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  mod12_run_ctrl_if #(.LEN_W(LEN_W)) bus ();
  mod12_run_ctrl #(.LEN_W(LEN_W), .MOD(12)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic             v0, v1, d0, d1;
  logic [3:0]       s0, s1;
  logic [LEN_W-1:0] l0, l1;
  assign bus.req0_valid = v0;
  assign bus.req0_start = s0;
  assign bus.req0_dir   = d0;
  assign bus.req0_len   = l0;
  assign bus.req1_valid = v1;
  assign bus.req1_start = s1;
  assign bus.req1_dir   = d1;
  assign bus.req1_len   = l1;

  // Shared counter; fault_req adds an offset of 5 once on the first stepping cycle
  logic [3:0] cnt;
  logic       fault_req, fault_used;
  assign bus.ctr_count = cnt;

  function automatic logic [3:0] cnt_step(input logic [3:0] v, input logic up);
    if (up) return (v == 4'd11) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? 4'd11 : v - 4'd1;
  endfunction

  always @(posedge clock) begin
    if (reset) cnt <= 4'd0;
    else if (bus.ctr_load) cnt <= bus.ctr_data;
    else if (fault_req && !fault_used) cnt <= 4'((32'(cnt_step(cnt, bus.ctr_mode)) + 5) % 12);
    else cnt <= cnt_step(cnt, bus.ctr_mode);
    fault_used <= fault_req && (fault_used || (!reset && !bus.ctr_load));
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference timeline: one command in flight, described by its accept cycle and fields
  int cyc = 0;
  bit act = 0, prio = 0, m_id, m_dir, m_fault;
  int m_acc, m_start, m_len;
  int last_id = 0, last_val = 0;

  task automatic mon();
    bit r0, r1, e_busy, e_done, e_load;
    int s, v, e;
    r0 = 0; r1 = 0; e_busy = 0; e_done = 0; e_load = 1;
    if (reset) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_done_err", bus.done_err, 0);
      check("rst_done_id", bus.done_id, 0);
      check("rst_done_value", bus.done_value, 0);
      act = 0; prio = 0; last_id = 0; last_val = 0;
      return;
    end
    if (act && cyc <= m_acc + 2 + m_len) begin
      e_busy = (cyc > m_acc);
      s = (m_start >= 12) ? 0 : m_start;
      if (cyc == m_acc + 1) check("load_data", bus.ctr_data, s);
      if (cyc >= m_acc + 2 && cyc <= m_acc + 1 + m_len) begin
        e_load = 0;
        check("run_mode", bus.ctr_mode, m_dir);
      end
      if (cyc == m_acc + 2 + m_len) begin
        e_done = 1;
        v = m_dir ? (s + m_len) % 12 : (s + 12 - m_len % 12) % 12;
        if (m_fault) v = (v + 5) % 12;
        e = (m_start >= 12 || m_fault) ? 1 : 0;
        check("done_id", bus.done_id, m_id);
        check("done_value", bus.done_value, v);
        check("done_err", bus.done_err, e);
        last_id = m_id; last_val = v;
      end
    end else begin
      act = 0;
      if (v0 && (!v1 || !prio)) r0 = 1;
      else if (v1) r1 = 1;
      if (r0 || r1) begin
        act = 1; m_acc = cyc; m_id = r1; m_fault = fault_req;
        m_start = r1 ? int'(s1) : int'(s0);
        m_dir   = r1 ? d1 : d0;
        m_len   = r1 ? int'(l1) : int'(l0);
        prio = ~m_id;
      end
    end
    check("ready0", bus.req0_ready, r0);
    check("ready1", bus.req1_ready, r1);
    check("busy", bus.busy, e_busy);
    check("done", bus.done, e_done);
    check("ctr_load", bus.ctr_load, e_load);
    if (!e_done) begin
      check("idle_done_err", bus.done_err, 0);
      check("hold_done_id", bus.done_id, last_id);
      check("hold_done_value", bus.done_value, last_val);
    end
  endtask

  // One clock: check at the falling edge, then drop any valid that was accepted
  task automatic run_cycle();
    bit g0, g1;
    @(negedge clock);
    mon();
    g0 = bus.req0_ready;
    g1 = bus.req1_ready;
    @(posedge clock);
    cyc++;
    #1;
    if (g0) v0 = 0;
    if (g1) v1 = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic arm(input int id, input int st, input int dir, input int len);
    if (id == 0) begin v0 = 1; s0 = 4'(st); d0 = dir[0]; l0 = LEN_W'(len); end
    else         begin v1 = 1; s1 = 4'(st); d1 = dir[0]; l1 = LEN_W'(len); end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((v0 || v1) && n < budget) begin run_cycle(); n++; end
    if (v0 || v1) begin
      check("accept_timeout", {30'd0, v1, v0}, 0);
      v0 = 0; v1 = 0;
    end
  endtask

  initial begin
    v0 = 0; v1 = 0; s0 = 0; s1 = 0; d0 = 0; d1 = 0; l0 = 0; l1 = 0;
    fault_req = 0; reset = 1;
    #1;
    idle(3);
    reset = 0;
    idle(2);

    arm(0, 10, 1, 3); drain(20); idle(6);
    arm(1, 1, 0, 4);  drain(20); idle(12);
    check("freeze_count", cnt, 9);

    arm(0, 4, 1, 2); arm(1, 7, 0, 1); drain(30); idle(6);
    arm(0, 2, 0, 3); arm(1, 8, 1, 2); drain(30); idle(8);

    arm(0, 5, 1, 0);  drain(20); idle(3);
    arm(1, 13, 1, 1); drain(20); idle(5);

    fault_req = 1;
    arm(0, 2, 1, 4); drain(20); idle(8);
    fault_req = 0;
    idle(1);

    arm(0, 3, 0, 10); drain(20); idle(3);
    reset = 1; idle(1); reset = 0;
    arm(0, 6, 1, 1); arm(1, 0, 0, 2); drain(30); idle(8);

    for (int i = 0; i < 400; i++) begin
      if (!v0 && $urandom_range(3, 0) == 0) arm(0, $urandom_range(15, 0), $urandom_range(1, 0), $urandom_range(15, 0));
      if (!v1 && $urandom_range(3, 0) == 0) arm(1, $urandom_range(15, 0), $urandom_range(1, 0), $urandom_range(15, 0));
      run_cycle();
    end
    drain(60);
    idle(25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
